serial_packer: RTL and testbench

Upstream stage of the 32-lane 4-bit dot-product engine. Accepts a serial nibble stream, assembles 32-nibble frames into 128-bit input (`I`) or weight (`W`) words, and issues them with single-cycle `in_valid` / `weight_valid` pulses. It issues one job at a time, holds new jobs until the engine returns `out_valid`, and preserves frame arrival order between weights and inputs.

---
 rtl/packer_pkg.sv | 24 ++
 rtl/nibble_collector.sv | 81 ++++++++
 rtl/serial_packer.sv | 131 +++++++++++++
 tb/tb_serial_packer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packer_pkg.sv
// -----------------------------------------------------------------------------
// packer_pkg
// Shared constants and types for the serial nibble packer that feeds the
// 32-lane 4-bit dot-product engine.
//   NIB_W      : width of one serial nibble
//   NIB_N      : nibbles per frame
//   WORD_W     : width of an assembled frame word
//   sel_e      : frame type carried on s_sel (input or weight)
//   ENGINE_LAT : cycles from an engine issue to its completion pulse
// -----------------------------------------------------------------------------
package packer_pkg;

    localparam int NIB_W      = 4;
    localparam int NIB_N      = 32;
    localparam int WORD_W     = NIB_W * NIB_N;

    typedef enum logic {
        SEL_INPUT  = 1'b0,
        SEL_WEIGHT = 1'b1
    } sel_e;

    localparam int ENGINE_LAT = 7;

endpackage

// File: rtl/nibble_collector.sv
// -----------------------------------------------------------------------------
// nibble_collector
// Assembles a serial nibble stream into frame words. Reports, in the same
// cycle as the accepting handshake, when a frame completes (with its type and
// the assembled word) or when a frame is aborted by a type switch.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   accept     : a nibble is taken this cycle (s_valid & s_ready)
//   s_sel      : frame type of the offered nibble
//   s_data     : offered nibble; the first nibble lands in the top bits
//   at_last    : the next accepted nibble would be the last of the frame
//   done       : a frame completes this cycle
//   done_sel   : type of the completing frame
//   word       : assembled word, valid while done is high
//   abort      : the accepted nibble switched type mid-frame
// -----------------------------------------------------------------------------
module nibble_collector #(
    parameter int NIB_W = packer_pkg::NIB_W,
    parameter int NIB_N = packer_pkg::NIB_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   accept,
    input  logic                   s_sel,
    input  logic [NIB_W-1:0]       s_data,
    output logic                   at_last,
    output logic                   done,
    output packer_pkg::sel_e       done_sel,
    output logic [NIB_W*NIB_N-1:0] word,
    output logic                   abort
);

    localparam int WORD_W = NIB_W * NIB_N;
    localparam int SH_W   = WORD_W - NIB_W;
    localparam int CNT_W  = $clog2(NIB_N);

    // Only the most recent NIB_N-1 nibbles are kept: the oldest one would be
    // shifted out by the nibble that completes the frame anyway, and the
    // completing nibble itself is taken straight from s_data.
    logic [SH_W-1:0]        sh;
    logic [CNT_W-1:0]       nib_cnt;
    packer_pkg::sel_e       frame_sel;

    // Frame status decode. An abort takes priority over completion: a
    // type-switching nibble always starts a fresh frame, even at the last slot.
    always_comb begin
        at_last  = (nib_cnt == CNT_W'(NIB_N - 1));
        abort    = accept && (nib_cnt != '0) && (s_sel != frame_sel);
        done     = accept && at_last && !abort;
        done_sel = frame_sel;
        word     = {sh, s_data};
    end

    // Shift register, nibble counter and frame type. On an abort the partial
    // data is dropped and the offending nibble becomes nibble 0 of a new frame
    // of its own type. The counter wraps to zero when a frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh        <= '0;
            nib_cnt   <= '0;
            frame_sel <= packer_pkg::SEL_INPUT;
        end else if (accept) begin
            if (abort) begin
                sh        <= SH_W'(s_data);
                nib_cnt   <= CNT_W'(1);
                frame_sel <= packer_pkg::sel_e'(s_sel);
            end else begin
                sh <= word[SH_W-1:0];
                if (nib_cnt == '0) begin
                    frame_sel <= packer_pkg::sel_e'(s_sel);
                end
                if (at_last) begin
                    nib_cnt <= '0;
                end else begin
                    nib_cnt <= nib_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/serial_packer.sv
// -----------------------------------------------------------------------------
// serial_packer
// Upstream stage of the dot-product engine. Collects serial nibble frames into
// input (I) and weight (W) words and issues one engine job at a time,
// preserving the arrival order of weight and input frames.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   s_valid       : a nibble is offered
//   s_sel         : frame type, 0 = input, 1 = weight
//   s_data        : nibble, first of a frame maps to the top bits
//   s_ready       : nibble accepted when s_valid & s_ready
//   ds_out_valid  : engine completion pulse
//   I, W          : held input and weight words
//   in_valid      : one-cycle input-issue pulse
//   weight_valid  : one-cycle weight-load pulse
//   err           : one-cycle frame-abort pulse
// -----------------------------------------------------------------------------
module serial_packer #(
    parameter int NIB_W = packer_pkg::NIB_W,
    parameter int NIB_N = packer_pkg::NIB_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    input  logic                   s_sel,
    input  logic [NIB_W-1:0]       s_data,
    output logic                   s_ready,
    input  logic                   ds_out_valid,
    output logic [NIB_W*NIB_N-1:0] I,
    output logic [NIB_W*NIB_N-1:0] W,
    output logic                   in_valid,
    output logic                   weight_valid,
    output logic                   err
);

    localparam int WORD_W = NIB_W * NIB_N;

    logic               accept;
    logic               at_last;
    logic               done;
    logic               abort;
    packer_pkg::sel_e   done_sel;
    logic [WORD_W-1:0]  word;

    logic [WORD_W-1:0]  i_hold;
    logic [WORD_W-1:0]  w_hold;
    logic               pend;
    logic               busy;
    logic               w_loaded;

    logic               in_done;
    logic               w_done;
    logic               issue;

    nibble_collector #(
        .NIB_W (NIB_W),
        .NIB_N (NIB_N)
    ) u_collector (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .s_sel    (s_sel),
        .s_data   (s_data),
        .at_last  (at_last),
        .done     (done),
        .done_sel (done_sel),
        .word     (word),
        .abort    (abort)
    );

    // A completing nibble of either type is held back while a job is waiting
    // for the engine, which keeps weight/input order intact. With no weights
    // loaded yet a weight frame may still complete, otherwise a pending input
    // could never be released.
    always_comb begin
        s_ready = !(pend && w_loaded && at_last);
        accept  = s_valid && s_ready;
    end

    // Issue decision. Completions of this cycle are folded in so that a job
    // becomes visible on in_valid the cycle right after its last nibble, and a
    // weight frame that releases a pending input issues together with
    // weight_valid (the engine then sees the new W).
    always_comb begin
        in_done = done && (done_sel == packer_pkg::SEL_INPUT);
        w_done  = done && (done_sel == packer_pkg::SEL_WEIGHT);
        issue   = (pend || in_done) && (w_loaded || w_done)
                  && (!busy || ds_out_valid);
    end

    // Word holding registers, job bookkeeping and the registered pulses.
    // busy is set by an issue and cleared by the engine's completion unless a
    // new job goes out in that same cycle; a completion while idle is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_hold       <= '0;
            w_hold       <= '0;
            pend         <= 1'b0;
            busy         <= 1'b0;
            w_loaded     <= 1'b0;
            in_valid     <= 1'b0;
            weight_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (in_done) begin
                i_hold <= word;
            end
            if (w_done) begin
                w_hold   <= word;
                w_loaded <= 1'b1;
            end
            if (issue) begin
                pend <= 1'b0;
            end else if (in_done) begin
                pend <= 1'b1;
            end
            if (issue) begin
                busy <= 1'b1;
            end else if (ds_out_valid) begin
                busy <= 1'b0;
            end
            in_valid     <= issue;
            weight_valid <= w_done;
            err          <= abort;
        end
    end

    assign I = i_hold;
    assign W = w_hold;

endmodule

// File: tb/tb_serial_packer.sv
// -----------------------------------------------------------------------------
// tb_serial_packer
// Directed bench for serial_packer. Expected issue/load events (cycle, I, W)
// are queued as frames are driven and compared when the DUT pulses. A small
// engine model answers each in_valid with ds_out_valid after a latency taken
// from a queue (ENGINE_LAT when the queue is empty).
// -----------------------------------------------------------------------------
module tb_serial_packer;
    import packer_pkg::*;

    typedef struct {
        int           cyc;
        logic [127:0] i;
        logic [127:0] w;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_sel = 1'b0;
    logic [3:0]   s_data = 4'h0;
    logic         s_ready;
    logic         ds_out_valid;
    logic [127:0] I;
    logic [127:0] W;
    logic         in_valid;
    logic         weight_valid;
    logic         err;

    logic         engine_fire = 1'b0;
    logic         stray_ds = 1'b0;

    int           cyc = 0;
    int           n_assert = 0;
    int           n_fail = 0;
    int           err_cnt = 0;
    int           err_cyc = 0;
    exp_t         in_q[$];
    exp_t         w_q[$];
    int           lat_q[$];
    int           ds_q[$];
    exp_t         mon_e;
    int           mon_lat;

    assign ds_out_valid = engine_fire | stray_ds;

    serial_packer dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_sel        (s_sel),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .ds_out_valid (ds_out_valid),
        .I            (I),
        .W            (W),
        .in_valid     (in_valid),
        .weight_valid (weight_valid),
        .err          (err)
    );

    // Free-running clock and a cycle counter used to time-stamp events.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Global time limit so a stuck run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end of test, required end within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic expectIn(input int c, input logic [127:0] iw, input logic [127:0] ww);
        exp_t e;
        e.cyc = c;
        e.i   = iw;
        e.w   = ww;
        in_q.push_back(e);
    endtask

    task automatic expectW(input int c, input logic [127:0] ww);
        exp_t e;
        e.cyc = c;
        e.i   = '0;
        e.w   = ww;
        w_q.push_back(e);
    endtask

    // Drives count nibbles of word (first nibble from the top bits), holding
    // each one until s_ready is seen; returns the accept cycle of the last
    // nibble and the number of stalled cycles. Entered and left at a posedge.
    task automatic applyStimulus(input logic sel, input logic [127:0] word, input int count,
                                 output int last_cyc, output int stalls);
        bit taken;
        stalls   = 0;
        last_cyc = 0;
        for (int i = 0; i < count; i++) begin
            taken = 1'b0;
            #1;
            s_valid = 1'b1;
            s_sel   = sel;
            s_data  = word[127-4*i -: 4];
            while (!taken) begin
                @(negedge clk);
                if (s_ready) begin
                    taken    = 1'b1;
                    last_cyc = cyc;
                end else begin
                    stalls++;
                    if (stalls > 200) begin
                        checkOutput("s_ready_timeout", s_ready, 1'b1);
                        taken = 1'b1;
                    end
                end
                @(posedge clk);
            end
        end
    endtask

    task automatic waitCycles(input int n);
        #1;
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic doReset(input string tag);
        #1;
        s_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_s_ready"}, s_ready, 1'b1);
        checkOutput({tag, "_in_valid"}, in_valid, 1'b0);
        checkOutput({tag, "_weight_valid"}, weight_valid, 1'b0);
        checkOutput({tag, "_err"}, err, 1'b0);
        checkOutput({tag, "_I"}, I, '0);
        checkOutput({tag, "_W"}, W, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_in_queue_left"}, in_q.size(), 0);
        checkOutput({tag, "_w_queue_left"}, w_q.size(), 0);
    endtask

    // Monitor: on each issue/load pulse, pop the next expected event and
    // compare its cycle and words; an unexpected pulse is a failure. Each
    // issue also schedules the engine model's completion pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid) begin
                if (in_q.size() == 0) begin
                    checkOutput("in_valid_unexpected", in_valid, 1'b0);
                end else begin
                    mon_e = in_q.pop_front();
                    checkOutput("in_valid_cycle", cyc, mon_e.cyc);
                    checkOutput("I_at_issue", I, mon_e.i);
                    checkOutput("W_at_issue", W, mon_e.w);
                end
                if (lat_q.size() > 0) mon_lat = lat_q.pop_front();
                else mon_lat = ENGINE_LAT;
                ds_q.push_back(cyc + mon_lat);
            end
            if (weight_valid) begin
                if (w_q.size() == 0) begin
                    checkOutput("weight_valid_unexpected", weight_valid, 1'b0);
                end else begin
                    mon_e = w_q.pop_front();
                    checkOutput("weight_valid_cycle", cyc, mon_e.cyc);
                    checkOutput("W_at_load", W, mon_e.w);
                end
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    // Engine model: fires ds_out_valid in the scheduled cycle, independent of
    // the packer's reset (a completion can therefore arrive as a stray pulse).
    always @(posedge clk) begin
        #1;
        engine_fire = 1'b0;
        if (ds_q.size() > 0 && ds_q[0] == cyc) begin
            engine_fire = 1'b1;
            void'(ds_q.pop_front());
        end
    end

    // Directed sequence.
    initial begin
        int t, t1, u, p, st;
        logic [127:0] w1, w_ones, w2, w3, w4, w5;
        w1     = 128'h123456789ABCDEF0123456789ABCDEF0;
        w_ones = {32{4'h1}};
        w2     = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
        w3     = {16{8'hA5}};
        w4     = 128'h0123456789ABCDEFFEDCBA9876543210;
        w5     = {32{4'hE}};

        @(posedge clk);
        doReset("reset0");

        $display("[TB] weight frame then input frame");
        applyStimulus(1'b1, w1, 32, t, st);
        expectW(t + 1, w1);
        applyStimulus(1'b0, {32{4'h2}}, 32, t, st);
        expectIn(t + 1, {32{4'h2}}, w1);
        waitCycles(12);
        checkDrained("basic");

        $display("[TB] input before any weight");
        doReset("reset1");
        applyStimulus(1'b0, {32{4'h3}}, 32, t, st);
        waitCycles(5);
        applyStimulus(1'b1, w_ones, 32, t, st);
        expectW(t + 1, w_ones);
        expectIn(t + 1, {32{4'h3}}, w_ones);
        waitCycles(12);
        checkDrained("release");

        $display("[TB] back-to-back inputs with a long first job");
        lat_q.push_back(70);
        applyStimulus(1'b0, {32{4'h4}}, 32, t1, st);
        expectIn(t1 + 1, {32{4'h4}}, w_ones);
        applyStimulus(1'b0, {32{4'h5}}, 32, t, st);
        checkOutput("b2b_second_no_stall", st, 0);
        expectIn(t1 + 72, {32{4'h5}}, w_ones);
        applyStimulus(1'b0, {32{4'h6}}, 32, t, st);
        checkOutput("b2b_stall_cycles", st, 8);
        checkOutput("b2b_release_cycle", t, t1 + 72);
        expectIn(t1 + 80, {32{4'h6}}, w_ones);
        waitCycles(20);
        checkDrained("b2b");

        $display("[TB] weight frame behind a pending input");
        lat_q.push_back(70);
        applyStimulus(1'b0, {32{4'h7}}, 32, u, st);
        expectIn(u + 1, {32{4'h7}}, w_ones);
        applyStimulus(1'b0, {32{4'h8}}, 32, t, st);
        expectIn(u + 72, {32{4'h8}}, w_ones);
        applyStimulus(1'b1, w2, 32, t, st);
        checkOutput("wpend_release_cycle", t, u + 72);
        expectW(u + 73, w2);
        waitCycles(20);
        checkDrained("wpend");

        $display("[TB] frame type switch mid-frame");
        err_cnt = 0;
        applyStimulus(1'b0, {32{4'hB}}, 10, p, st);
        applyStimulus(1'b1, w3, 32, t, st);
        checkOutput("abort_weight_end", t, p + 32);
        expectW(t + 1, w3);
        waitCycles(12);
        checkOutput("abort_err_count", err_cnt, 1);
        checkOutput("abort_err_cycle", err_cyc, p + 2);
        checkDrained("abort");

        $display("[TB] reset mid-frame and while busy");
        applyStimulus(1'b1, w4, 20, t, st);
        doReset("reset_mid_frame");
        applyStimulus(1'b1, w4, 32, t, st);
        expectW(t + 1, w4);
        waitCycles(4);
        applyStimulus(1'b0, {32{4'hC}}, 32, t, st);
        expectIn(t + 1, {32{4'hC}}, w4);
        waitCycles(2);
        doReset("reset_busy");
        waitCycles(6);
        applyStimulus(1'b0, {32{4'hD}}, 32, t, st);
        #1;
        stray_ds = 1'b1;
        @(posedge clk);
        #1;
        stray_ds = 1'b0;
        waitCycles(4);
        applyStimulus(1'b1, w5, 32, t, st);
        expectW(t + 1, w5);
        expectIn(t + 1, {32{4'hD}}, w5);
        waitCycles(12);
        checkDrained("post_reset");
        checkOutput("engine_idle", ds_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
